// File: rtl/hex_display_pkg.sv
// Shared constants, segment lookup and scan-state helpers for the hex display scanner.
package hex_display_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;

  typedef logic [SEG_W-1:0] seg_t;

  // {g,f,e,d,c,b,a}, 1 = lit
  localparam seg_t SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic ST_SCAN = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  function automatic logic scan_next_state(input logic state, input logic accept,
                                           input logic wrap);
    logic next;
    next = state;
    if (state == ST_SCAN) begin
      if (accept) next = ST_HOLD;
    end else begin
      if (wrap) next = ST_SCAN;
    end
    return next;
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to 7-segment lookup shared by all scanned digits.
module hex_seg_decode
  import hex_display_pkg::*;
(
  input  logic [NIB_W-1:0] i_nibble,
  output logic [SEG_W-1:0] o_seg
);

  assign o_seg = SEG_LUT[i_nibble];

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed scanner for a multi-digit hex display with a double-buffered value.
// Optional leading-zero suppression is enabled by defining HEX_LEADING_ZERO_BLANK_EN.
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned GUARD      = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_load_valid,
  output logic                        o_load_ready,
  input  logic [NIB_W*NUM_DIGITS-1:0] i_load_data,
  input  logic [NUM_DIGITS-1:0]       i_blank_mask,
  output logic [NUM_DIGITS-1:0]       o_digit_en,
  output logic [SEG_W-1:0]            o_seg_out,
  output logic                        o_frame_done
);

  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DATA_W = NIB_W * NUM_DIGITS;

  localparam logic [DIV_WIDTH-1:0] TERM_CNT  = DIV_WIDTH'(SCAN_DIV - 1);
  localparam logic [DIV_WIDTH-1:0] GUARD_CNT = DIV_WIDTH'(GUARD);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_WIDTH-1:0]  r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_W-1:0]     r_active;
  logic [DATA_W-1:0]     r_pending;
  logic                  r_state;
  logic [NUM_DIGITS-1:0] r_digit_en;
  logic [SEG_W-1:0]      r_seg;
  logic                  r_frame_done;

  logic                  w_term;
  logic                  w_wrap;
  logic                  w_accept;
  logic                  w_state_next;
  logic [NUM_DIGITS-1:0] w_dark;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic [NIB_W-1:0]      w_nibble;
  logic                  w_sel_dark;
  logic [SEG_W-1:0]      w_seg;

  assign w_term       = (r_cnt == TERM_CNT);
  assign w_wrap       = w_term && (r_idx == LAST_IDX);
  assign w_accept     = i_load_valid && (r_state == ST_SCAN);
  assign w_state_next = scan_next_state(r_state, w_accept, w_wrap);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_term) begin
      r_cnt <= '0;
      r_idx <= w_wrap ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Active data only changes on the frame wrap, so a frame is never torn.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_SCAN;
      r_pending <= '0;
      r_active  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) r_pending <= i_load_data;
      if (w_wrap && (r_state == ST_HOLD)) r_active <= r_pending;
    end
  end

`ifdef HEX_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_lead_zero;
  logic                  w_upper_zero;

  // Walk down from the top digit; digit 0 always shows.
  always_comb begin
    w_lead_zero  = '0;
    w_upper_zero = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      w_upper_zero   = w_upper_zero && (r_active[NIB_W*i +: NIB_W] == '0);
      w_lead_zero[i] = w_upper_zero && (i != 0);
    end
  end

  assign w_dark = i_blank_mask | w_lead_zero;
`else
  assign w_dark = i_blank_mask;
`endif

  always_comb begin
    w_nibble   = '0;
    w_onehot   = '0;
    w_sel_dark = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nibble    = r_active[NIB_W*i +: NIB_W];
        w_onehot[i] = 1'b1;
        w_sel_dark  = w_dark[i];
      end
    end
  end

  hex_seg_decode u_seg_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_digit_en   <= '0;
      r_seg        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      if (r_cnt < GUARD_CNT) begin
        r_digit_en <= '0;
        r_seg      <= '0;
      end else begin
        r_digit_en <= w_onehot;
        r_seg      <= w_sel_dark ? '0 : w_seg;
      end
    end
  end

  assign o_load_ready = (r_state == ST_SCAN);
  assign o_digit_en   = r_digit_en;
  assign o_seg_out    = r_seg;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench for hex_display_scanner against a frame-level behavioural model.
module tb_hex_display_scanner;

  localparam int N     = 6;
  localparam int D     = 4;
  localparam int G     = 1;
  localparam int FRAME = N * D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [23:0] load_data = '0;
  logic [5:0]  blank_mask = '0;
  logic [5:0]  digit_en;
  logic [6:0]  seg_out;
  logic        frame_done;

  always #5 clk = ~clk;

  hex_display_scanner #(
    .NUM_DIGITS (N),
    .SCAN_DIV   (D),
    .DIV_WIDTH  (4),
    .GUARD      (G)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_load_valid (load_valid),
    .o_load_ready (load_ready),
    .i_load_data  (load_data),
    .i_blank_mask (blank_mask),
    .o_digit_en   (digit_en),
    .o_seg_out    (seg_out),
    .o_frame_done (frame_done)
  );

  typedef struct {
    int         cyc;
    logic [5:0] en;
    logic [6:0] seg;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [6:0] lut [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Reference model: elapsed ticks since reset plus the two display buffers.
  int unsigned m_tick;
  logic [23:0] m_active;
  logic [23:0] m_pending;
  bit          m_has_pend;
  logic [23:0] want_data = '0;
  bit          want_offer = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  function automatic bit lead_blank(input logic [23:0] v, input int d);
`ifdef HEX_LEADING_ZERO_BLANK_EN
    return (d != 0) && ((v >> (4 * d)) == 24'h0);
`else
    return (v === 24'hx) && (d < 0);
`endif
  endfunction

  task automatic model_reset();
    m_tick     = 0;
    m_active   = '0;
    m_pending  = '0;
    m_has_pend = 1'b0;
    want_offer = 1'b0;
  endtask

  // Issue one clock of stimulus and queue what the outputs must show after that edge.
  task automatic step();
    int         pos;
    int         dig;
    bit         wrap;
    bit         acc;
    logic [3:0] nib;
    exp_t       e;
    load_valid = want_offer;
    load_data  = want_data;
    pos  = int'(m_tick % D);
    dig  = int'((m_tick / D) % N);
    wrap = (m_tick % FRAME) == FRAME - 1;
    nib  = m_active[4*dig +: 4];
    e.cyc = cyc + 1;
    if (pos < G) begin
      e.en  = '0;
      e.seg = '0;
    end else begin
      e.en  = 6'(1 << dig);
      e.seg = (blank_mask[dig] || lead_blank(m_active, dig)) ? 7'h00 : lut[nib];
    end
    e.fd = wrap;
    acc  = want_offer && !m_has_pend;
    if (wrap && m_has_pend) begin
      m_active   = m_pending;
      m_has_pend = 1'b0;
    end
    if (acc) begin
      m_pending  = want_data;
      m_has_pend = 1'b1;
      want_offer = 1'b0;
    end
    e.rdy = !m_has_pend;
    sb.push_back(e);
    m_tick++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Producer keeps data stable until it is taken.
  task automatic offer(input logic [23:0] v);
    int guard = 0;
    while (want_offer && guard < 200) begin
      step();
      guard++;
    end
    if (want_offer) check("offer_timeout", 32'(guard), 32'd0);
    want_data  = v;
    want_offer = 1'b1;
  endtask

  task automatic offer_at_wrap(input logic [23:0] v);
    int guard = 0;
    while ((want_offer || m_has_pend || (m_tick % FRAME) != FRAME - 1) && guard < 200) begin
      step();
      guard++;
    end
    if (guard >= 200) check("wrap_align_timeout", 32'(guard), 32'd0);
    want_data  = v;
    want_offer = 1'b1;
  endtask

  task automatic do_reset(input int hold);
    #2;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    #1;
    check("rst_digit_en", 32'(digit_en), 32'd0);
    check("rst_seg_out", 32'(seg_out), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd1);
    sb.delete();
    repeat (hold) @(negedge clk);
    check("rst_hold_digit_en", 32'(digit_en), 32'd0);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc != cyc) begin
        check("sb_sync", 32'(e.cyc), 32'(cyc));
      end else begin
        check("digit_en", 32'(digit_en), 32'(e.en));
        check("seg_out", 32'(seg_out), 32'(e.seg));
        check("frame_done", 32'(frame_done), 32'(e.fd));
        check("load_ready", 32'(load_ready), 32'(e.rdy));
        check("onehot", 32'($countones(digit_en) <= 1), 32'd1);
      end
    end
  end

  initial begin
    logic [23:0] rd;
    model_reset();
    @(negedge clk);
    do_reset(2);
    run(3);

    offer(24'h123456);
    run(3 * FRAME);

    offer(24'h111111);
    offer(24'hABCDEF);
    run(3 * FRAME);

    offer_at_wrap(24'h2468AC);
    run(3 * FRAME);

    blank_mask = 6'b000100;
    offer(24'h888888);
    run(3 * FRAME);
    blank_mask = '0;

    offer(24'h00000A);
    run(2 * FRAME);
    offer(24'h000000);
    run(2 * FRAME);

    // Reset while a value is pending: it must be discarded.
    offer(24'h654321);
    run(3);
    do_reset(3);
    run(2 * FRAME);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) blank_mask = 6'($urandom);
      if (!want_offer && $urandom_range(0, 1) == 1) begin
        rd = ($urandom_range(0, 1) == 1) ? 24'($urandom)
                                         : 24'($urandom >> (4 * $urandom_range(2, 7)));
        offer(rd);
      end
      run($urandom_range(1, 30));
    end

    repeat (2) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Time-multiplexed scan controller for the 6-digit hex display.
- Holds a double-buffered 24-bit display value and cycles one shared nibble-to-segment decoder across all digits.
- Drives one-hot digit enables plus a single 7-bit segment bus.
- Sits between the system-side value producer (valid/ready) and the board's common-segment display pins.

Parameters:
NUM_DIGITS, 6, digits scanned; load_data width = 4*NUM_DIGITS
SCAN_DIV, 50000, clk cycles each digit is dwelled on; must be >= GUARD+2
DIV_WIDTH, 16, width of dwell counter; must hold SCAN_DIV-1
GUARD, 2, cycles at start of each dwell with all digit enables off (anti-ghosting)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
load_valid  in  1  producer offers load_data
load_ready  out  1  block can accept load_data
load_data  in  4*NUM_DIGITS  nibble i = load_data[4i+3:4i] shown on digit i
blank_mask  in  NUM_DIGITS  bit i=1 forces digit i dark; sampled live
digit_en  out  NUM_DIGITS  one-hot digit enable, active-high
seg_out  out  7  {g,f,e,d,c,b,a}, 1 = segment lit
frame_done  out  1  one-cycle pulse when scan wraps from digit NUM_DIGITS-1 to 0

Behaviour:
- Reset (rst low, async): active and pending registers = 0; pending_valid = 0; dwell counter = 0; digit index = 0; digit_en = 0; seg_out = 0; frame_done = 0; load_ready = 1. Reset mid-frame or mid-handshake discards pending data immediately.
- Dwell counter counts 0..SCAN_DIV-1 and wraps. Terminal count advances digit index (NUM_DIGITS-1 wraps to 0).
- frame_done asserts in the cycle after the index wrap (registered).
- States: SCAN (pending_valid=0, load_ready=1) and HOLD (pending_valid=1, load_ready=0).
  - SCAN -> HOLD on load_valid && load_ready; load_data captured into pending.
  - HOLD -> SCAN on the wrap cycle: pending copied to active; load_ready returns to 1 the next cycle.
- Display is never torn: active data changes only at frame boundaries.
- Simultaneous accept and wrap in SCAN: data goes to pending, is not swapped this wrap, and is swapped at the following wrap. Wrap in SCAN makes no change.
- load_valid low in HOLD: no effect. Producer holds valid/data until ready.
- Output pipeline: digit_en and seg_out are registered, one cycle behind the counter/index state.
  - While counter < GUARD: digit_en = 0, seg_out = 0.
  - Otherwise: digit_en = 1<<index, seg_out = decode(active nibble[index]).
  - If blank_mask[index]=1: seg_out = 0, and digit_en still asserts.
- Decode table (hex 0-F): 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- At most one digit_en bit is high in any cycle.

Optional Feature:
- Macro: HEX_LEADING_ZERO_BLANK_EN.
- Defined: any zero nibble with only zero nibbles above it (higher digit indices) is blanked as if its blank_mask bit were set. Digit 0 is never suppressed, so a value of 0 shows "0" on digit 0. Computed from active data each cycle; no extra latency.
- Undefined: all digits decode normally; blanking is controlled by blank_mask only.

Decomposition:
- Package hex_display_pkg:
  - SEG_W=7, NIB_W=4
  - 16-entry segment lookup constant
  - typedef for the segment vector
  - function for the scan state encoding
- Sub-module hex_seg_decode: combinational nibble -> 7-bit segment lookup, one instance.
- Counter, handshake and leading-zero logic stay in the top.

Test Plan:
Bench parameters: NUM_DIGITS=6, SCAN_DIV=4, GUARD=1.
1. Reset: hold rst low mid-run -> digit_en=000000, seg_out=00, frame_done=0, load_ready=1 immediately (async); after release, first digit_en=000001 appears at counter=1 plus one cycle.
2. Load 0x123456 with valid one cycle -> load_ready falls next cycle. After next frame_done: digit 0 shows 0x7D ("6"), digit 5 shows 0x06 ("1"); load_ready rises one cycle after the swap.
3. Handshake: assert valid with 0xABCDEF while in HOLD -> not accepted until load_ready=1; the old frame stays intact; the new value appears only after the following wrap. Also check accept coinciding with the wrap cycle -> swap occurs at the second wrap.
4. Guard and one-hot: over 3 frames, digit_en is 0 for exactly 1 cycle per dwell, never has >1 bit set, and frame_done pulses every 24 cycles.
5. blank_mask=6'b000100 with 0x888888 -> digit 2 seg_out=00 while digit_en=000100; other digits 0x7F.
6. Value 0x00000A: with HEX_LEADING_ZERO_BLANK_EN, digits 5..1 give seg_out=00 and digit 0 gives 0x77. Without it, digits 5..1 give 0x3F. Value 0x000000 with macro -> digit 0 gives 0x3F.
